// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: CSR addresses, csr_op
// encodings, mstatus bit positions and the read-modify-write helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_TIMER_BIT = 7;
  localparam int IRQ_EXT_BIT   = 11;
  localparam logic [31:0] MIE_MASK = 32'h0000_0880;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old_val | wdata;
      CSR_OP_RC: return old_val & ~wdata;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit wrapping event counter whose 32-bit halves can be overwritten
// independently; a half write wins over the increment and blocks the carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  logic [63:0] value_q, value_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it holding and no latch is inferred.
  always_comb begin
    value_d = value_q + {63'd0, inc};
    if (wr_lo) value_d = {value_q[63:32], wdata};
    if (wr_hi) value_d[63:32] = wdata;
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap entry/return and interrupt pending logic.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle and minstret counters.
module csr_unit import csr_pkg::*; #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        retire,
  input  logic        irq_ext,
  input  logic        irq_timer,
  output logic [31:0] out_trap_vec,
  output logic [31:0] out_exception_pc,
  output logic        irq_pending
);

  csr_op_e     op;
  logic        status_mie_q, status_mie_d;
  logic        status_mpie_q, status_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [31:0] mstatus_rd, mip_rd, new_val, trap_base;
  logic        addr_known, write_attempt, wr_en;

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`endif

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_rd[MSTATUS_MPIE] = status_mpie_q;
    mstatus_rd[MSTATUS_MIE]  = status_mie_q;
    mip_rd = '0;
    mip_rd[IRQ_EXT_BIT]   = irq_ext;
    mip_rd[IRQ_TIMER_BIT] = irq_timer;
  end

  always_comb begin
    csr_rdata  = '0;
    addr_known = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MISA:      csr_rdata = MISA_VAL;
      CSR_MIE:       csr_rdata = mie_q;
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_MTVAL:     csr_rdata = mtval_q;
      CSR_MIP:       csr_rdata = mip_rd;
      CSR_MVENDORID: csr_rdata = '0;
      CSR_MARCHID:   csr_rdata = '0;
      CSR_MIMPID:    csr_rdata = '0;
      CSR_MHARTID:   csr_rdata = MHARTID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:       addr_known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal even on read-only space.
  assign write_attempt = (op == CSR_OP_RW) || (csr_wdata != '0);
  assign csr_illegal   = csr_en && (op != CSR_OP_NONE) &&
                         (!addr_known || (write_attempt && (csr_addr[11:10] == 2'b11)));
  assign wr_en   = csr_en && (op != CSR_OP_NONE) && !csr_illegal && write_attempt &&
                   !trap_valid && !mret;
  assign new_val = csr_apply(op, csr_rdata, csr_wdata);

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (trap_valid) begin
      mepc_d        = trap_pc & ~32'h3;
      mcause_d      = trap_cause;
      mtval_d       = trap_tval;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else if (mret) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          status_mie_d  = new_val[MSTATUS_MIE];
          status_mpie_d = new_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie_d      = new_val & MIE_MASK;
        CSR_MTVEC:    mtvec_d    = new_val & ~32'h2;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~32'h3;
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RESET & ~32'h2;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr_en && (csr_addr == CSR_MCYCLE)),
    .wr_hi (wr_en && (csr_addr == CSR_MCYCLEH)),
    .wdata (new_val),
    .value (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .wr_lo (wr_en && (csr_addr == CSR_MINSTRET)),
    .wr_hi (wr_en && (csr_addr == CSR_MINSTRETH)),
    .wdata (new_val),
    .value (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Vectored mode applies only to interrupts, selected by the registered mcause.
  assign trap_base    = {mtvec_q[31:2], 2'b00};
  assign out_trap_vec = (mtvec_q[0] && mcause_q[31]) ?
                        trap_base + {25'd0, mcause_q[4:0], 2'b00} : trap_base;
  assign out_exception_pc = mepc_q;
  assign irq_pending      = status_mie_q && ((mie_q & mip_rd) != '0);

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter MTVEC_RESET, 32'h0000_0000, mtvec value after reset.
REQ-002 SHALL have parameter MHARTID, 0, value returned by mhartid (0xF14).
REQ-003 SHALL have parameter MISA_VAL, 32'h4000_0100, value returned by misa (0x301); this is RV32I.
REQ-004 SHALL have ports; one clock; reset is synchronous and active-high:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_en  in  1  CSR instruction valid this cycle
- csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
- csr_addr  in  12  CSR address; used for both read and write
- csr_wdata  in  32  rs1 or immediate operand
- csr_rdata  out  32  combinational read of csr_addr
- csr_illegal  out  1  combinational illegal-access flag
- trap_valid  in  1  trap entry request
- trap_cause  in  32  mcause value
- trap_pc  in  32  faulting PC
- trap_tval  in  32  mtval value
- mret  in  1  trap return
- retire  in  1  one instruction retired
- irq_ext  in  1  external interrupt level
- irq_timer  in  1  timer interrupt level
- out_trap_vec  out  32  trap target PC
- out_exception_pc  out  32  mepc
- irq_pending  out  1  interrupt should be taken

Function
REQ-005 SHALL implement these CSRs: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mvendorid F11, marchid F12, mimpid F13, mhartid F14.
REQ-006 mvendorid, marchid and mimpid SHALL read 0.
REQ-007 Any other address SHALL read 0 and assert csr_illegal when csr_en=1 and csr_op!=0.
REQ-008 A write with csr_addr[11:10]==2'b11 SHALL assert csr_illegal.
- Exception: RS/RC with csr_wdata==0 is a legal read and performs no write.
REQ-009 A CSR write SHALL commit at posedge clk when csr_en=1, csr_op!=0, csr_illegal=0 and trap_valid=0.
- New value: RW=wdata, RS=old|wdata, RC=old&~wdata.
- csr_rdata SHALL return the old value in the same cycle.
REQ-010 mstatus SHALL implement only MIE[3], MPIE[7] and MPP[12:11]; all other bits read 0.
REQ-011 MPP SHALL always read 2'b11.
REQ-012 mtvec[1] SHALL be forced to 0; mode = mtvec[0].
REQ-013 Writes to misa SHALL be ignored.
REQ-014 mepc[1:0] SHALL be forced to 0 on every write path.
REQ-015 mip[11] SHALL equal irq_ext and mip[7] SHALL equal irq_timer, sampled combinationally.
REQ-016 mip SHALL ignore writes; all other mip bits read 0.
REQ-017 mie SHALL implement only bits 11 and 7.
REQ-018 irq_pending SHALL equal mstatus.MIE & |(mie & mip).
REQ-019 On trap_valid at posedge, the unit SHALL apply in the same edge:
- mepc <= trap_pc & ~3
- mcause <= trap_cause
- mtval <= trap_tval
- MPIE <= MIE, MIE <= 0
REQ-020 On mret at posedge (trap_valid=0), the unit SHALL set MIE <= MPIE and MPIE <= 1.
REQ-021 Same-edge update priority SHALL be: reset > trap_valid > mret > CSR write.
- A CSR write coincident with mret SHALL be dropped.
REQ-022 out_trap_vec SHALL be {mtvec[31:2],2'b00}, except when mtvec[0]=1 and mcause[31]=1.
- In that case it is that base + 4*mcause[4:0], using the registered mcause.
REQ-023 out_exception_pc SHALL equal the registered mepc.

Reset
REQ-024 On reset at posedge, all registers except mtvec SHALL be set to 0.
- This covers mstatus (MPP still reads 11), mie, mscratch, mepc, mcause, mtval and counters.
- mtvec SHALL be set to MTVEC_RESET & ~32'h2.
REQ-025 Reset SHALL override a simultaneous trap_valid, mret or write.
- Outputs SHALL reflect reset values from the next cycle.

Configuration
REQ-026 With CSR_COUNTERS_EN defined, the unit SHALL provide 64-bit mcycle and minstret.
- Addresses: mcycle B00/B80, minstret B02/B82.
- mcycle increments every non-reset cycle; minstret increments when retire=1.
- Both wrap from 2^64-1 to 0.
- A CSR write to a counter half SHALL win over that cycle's increment; the other half keeps its incremented value, with carry suppressed.
REQ-027 Without CSR_COUNTERS_EN, no counter logic SHALL exist.
- B00, B02, B80 and B82 SHALL behave as unimplemented (REQ-007).

Structure
REQ-028 Package csr_pkg SHALL hold:
- CSR address constants
- csr_op encodings
- mstatus bit-position constants
REQ-029 When CSR_COUNTERS_EN is defined, the two counters SHALL be instances of sub-module csr_counter64.
- Ports: clk, reset, inc, wr_lo, wr_hi, wdata, value.

Verification
REQ-030 The bench SHALL cover:
- Reset with MTVEC_RESET=0x8000_0003 -> mtvec reads 0x8000_0001, mstatus reads 0x0000_1800, mepc 0.
- RS 0x304 wdata 0x880 with irq_timer=1 -> mie=0x880; after RS 0x300 wdata 0x8, irq_pending=1.
- trap_valid with pc 0x1236, cause 0x8000_0007, mtvec 0x100 mode 1 -> mepc 0x1234, out_trap_vec 0x11C, MIE 0, MPIE 1; then mret -> MIE 1.
- RW 0xF14 -> csr_illegal=1, no state change; RS 0xF14 wdata 0 -> csr_illegal=0, reads MHARTID.
- Counters: RW 0xB00 0xFFFF_FFFF -> next cycle mcycle=0x0000_0000_FFFF_FFFF; one cycle later 0x0000_0001_0000_0000.
- trap_valid coincident with RW 0x341 0xDEAD -> mepc = trap_pc & ~3, write dropped.
